// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the MEM-stage data-memory arbiter: default widths, FSM state
// and the per-requester memory request record.
package dmem_arbiter_pkg;

   localparam int ADDR_W_DEF    = 32;
   localparam int DATA_W_DEF    = 32;
   localparam int MEM_WORDS_DEF = 256;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } arb_state_t;

   // Sized for the default widths; both requester ports are packed into this.
   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } mem_req_t;

   function automatic int bytes_per_word(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of pipeline, loader and memory-side signals around the arbiter.
// slave = arbiter side, master = surrounding pipeline/loader/memory.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              p_req;
   logic              p_we;
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_wdata;
   logic              p_stall;
   logic [DATA_W-1:0] p_rdata;
   logic              p_misalign;

   logic              l_req;
   logic              l_we;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_gnt;
   logic              l_rvalid;
   logic [DATA_W-1:0] l_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              init_done;

   modport slave (
      input  p_req, p_we, p_addr, p_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
      output p_stall, p_rdata, p_misalign, l_gnt, l_rvalid, l_rdata,
             mem_addr, mem_we, mem_wdata, init_done
   );

   modport master (
      output p_req, p_we, p_addr, p_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
      input  p_stall, p_rdata, p_misalign, l_gnt, l_rvalid, l_rdata,
             mem_addr, mem_we, mem_wdata, init_done
   );
endinterface

// File: rtl/dmem_arbiter_clear_seq.sv
// Post-reset clear sweep: walks every word index once, then latches done.
import dmem_arbiter_pkg::*;

module dmem_clear_seq #(
   parameter  int MEM_WORDS = MEM_WORDS_DEF,
   localparam int CNT_W     = $clog2(MEM_WORDS)
) (
   input  logic             clock,
   input  logic             rst,
   output logic [CNT_W-1:0] cnt,
   output logic             last,
   output logic             done
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   // Counter wraps to 0 on the final word and then parks there.
   always_comb begin
      last   = !done_q && (cnt_q == CNT_W'(MEM_WORDS - 1));
      cnt_d  = done_q ? cnt_q : cnt_q + CNT_W'(1);
      done_d = done_q | last;
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign cnt  = cnt_q;
   assign done = done_q;
endmodule

// File: rtl/dmem_arbiter.sv
// Single data-memory port shared by pipeline (P) and loader (L), with a clear
// sweep after reset. Define DMEM_ARB_STATS_EN to add stall / L-grant counters.
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MEM_WORDS = MEM_WORDS_DEF,
   parameter int MAX_WAIT  = 4
) (
   input  logic             clock,
   input  logic             rst,
   dmem_arbiter_if.slave    bus
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]      stat_stall,
   output logic [31:0]      stat_lgnt
`endif
);
   localparam int BPI   = bytes_per_word(DATA_W);
   localparam int OFF_W = $clog2(BPI);
   localparam int CNT_W = $clog2(MEM_WORDS);
   // Drops the in-word offset and everything above the memory span.
   localparam logic [ADDR_W-1:0] ADDR_MASK =
      ADDR_W'(MEM_WORDS * BPI - 1) & ~ADDR_W'(BPI - 1);
   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   arb_state_t        state_q;
   logic [CNT_W-1:0]  sweep_cnt;
   logic              sweep_last;
   logic              sweep_done;

   logic [3:0]        wait_q, wait_d;
   logic              l_rvalid_q, l_rvalid_d;
   logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
   logic              misalign_q, misalign_d;

   mem_req_t          p_bus, l_bus, sel;
   logic              gnt_p, gnt_l, stall;

   dmem_clear_seq #(.MEM_WORDS(MEM_WORDS)) u_clear (
      .clock (clock),
      .rst   (rst),
      .cnt   (sweep_cnt),
      .last  (sweep_last),
      .done  (sweep_done)
   );

   always_ff @(posedge clock) begin
      if (rst)
         state_q <= ST_INIT;
      else if (state_q == ST_INIT && sweep_last)
         state_q <= ST_RUN;
   end

   assign p_bus = '{we: bus.p_we, addr: bus.p_addr, wdata: bus.p_wdata};
   assign l_bus = '{we: bus.l_we, addr: bus.l_addr, wdata: bus.l_wdata};

   // A starved loader pre-empts the pipeline once it has waited MAX_WAIT cycles.
   always_comb begin
      gnt_p = 1'b0;
      gnt_l = 1'b0;
      stall = 1'b0;
      sel   = '0;
      if (state_q == ST_INIT) begin
         stall    = bus.p_req;
         sel.we   = 1'b1;
         sel.addr = ADDR_W'({sweep_cnt, {OFF_W{1'b0}}});
      end else if (wait_q == WAIT_MAX && bus.l_req) begin
         gnt_l = 1'b1;
         stall = bus.p_req;
         sel   = l_bus;
      end else if (bus.p_req) begin
         gnt_p = 1'b1;
         sel   = p_bus;
      end else if (bus.l_req) begin
         gnt_l = 1'b1;
         sel   = l_bus;
      end
   end

   // Wait aging only runs once arbitration is live.
   always_comb begin
      wait_d = wait_q;
      if (state_q == ST_INIT || !bus.l_req || gnt_l)
         wait_d = '0;
      else if (wait_q != WAIT_MAX)
         wait_d = wait_q + 4'd1;
      l_rvalid_d = gnt_l & ~bus.l_we;
      l_rdata_d  = l_rvalid_d ? bus.mem_rdata : l_rdata_q;
      misalign_d = misalign_q | (gnt_p & (|bus.p_addr[OFF_W-1:0]));
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         wait_q     <= '0;
         l_rvalid_q <= 1'b0;
         l_rdata_q  <= '0;
         misalign_q <= 1'b0;
      end else begin
         wait_q     <= wait_d;
         l_rvalid_q <= l_rvalid_d;
         l_rdata_q  <= l_rdata_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.mem_addr   = sel.addr & ADDR_MASK;
   assign bus.mem_we     = sel.we;
   assign bus.mem_wdata  = sel.wdata;
   assign bus.p_stall    = stall;
   assign bus.p_rdata    = bus.mem_rdata;
   assign bus.p_misalign = misalign_q;
   assign bus.l_gnt      = gnt_l;
   assign bus.l_rvalid   = l_rvalid_q;
   assign bus.l_rdata    = l_rdata_q;
   assign bus.init_done  = sweep_done;

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] stat_stall_q, stat_stall_d;
   logic [31:0] stat_lgnt_q,  stat_lgnt_d;

   always_comb begin
      stat_stall_d = stat_stall_q + 32'((state_q == ST_RUN) && stall);
      stat_lgnt_d  = stat_lgnt_q + 32'(gnt_l);
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         stat_stall_q <= '0;
         stat_lgnt_q  <= '0;
      end else begin
         stat_stall_q <= stat_stall_d;
         stat_lgnt_q  <= stat_lgnt_d;
      end
   end

   assign stat_stall = stat_stall_q;
   assign stat_lgnt  = stat_lgnt_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural reference checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;
   localparam int MW   = 256;
   localparam int MAXW = 4;

   logic clock = 1'b0;
   logic rst   = 1'b1;
   int   checks = 0;
   int   errors = 0;

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] stat_stall, stat_lgnt;
   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(MW), .MAX_WAIT(MAXW)) dut (
      .clock(clock), .rst(rst), .bus(bus), .stat_stall(stat_stall), .stat_lgnt(stat_lgnt));
`else
   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(MW), .MAX_WAIT(MAXW)) dut (
      .clock(clock), .rst(rst), .bus(bus));
`endif

   always #5 clock = ~clock;

   // Memory the arbiter drives; starts with junk so the sweep is visible.
   logic [31:0] mem [MW];
   initial for (int i = 0; i < MW; i++) mem[i] = 32'hA5A5_A5A5;
   always @(posedge clock) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
   assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: cycles since reset, refusal streak of L, read-return pending,
   // sticky misalign and a shadow image of memory contents.
   bit          m_valid = 1'b0;
   int          m_cyc, m_wait;
   bit          m_rv, m_mis;
   logic [31:0] m_rd;
   logic [31:0] shadow [MW];

   always @(negedge clock) begin : compare
      bit          in_init;
      int          who;   // 0 none, 1 pipeline, 2 loader
      bit          ewe, estall;
      logic [31:0] ea, ewd;
      in_init = 1'b0; who = 0; ewe = 1'b0; estall = 1'b0; ea = 32'd0; ewd = 32'd0;
      if (m_valid) begin
         in_init = (m_cyc < MW);
         if (in_init) begin
            ea = 32'(m_cyc * 4); ewe = 1'b1; estall = bus.p_req;
         end else begin
            if (bus.l_req && m_wait >= MAXW) begin who = 2; estall = bus.p_req; end
            else if (bus.p_req) who = 1;
            else if (bus.l_req) who = 2;
            if (who == 1) begin
               ea = ((bus.p_addr % 32'd1024) / 32'd4) * 32'd4; ewe = bus.p_we; ewd = bus.p_wdata;
            end else if (who == 2) begin
               ea = ((bus.l_addr % 32'd1024) / 32'd4) * 32'd4; ewe = bus.l_we; ewd = bus.l_wdata;
            end
         end
         chk("init_done",  32'(bus.init_done),  32'(!in_init));
         chk("mem_we",     32'(bus.mem_we),     32'(ewe));
         chk("mem_addr",   bus.mem_addr,        ea);
         if (ewe) chk("mem_wdata", bus.mem_wdata, ewd);
         chk("p_stall",    32'(bus.p_stall),    32'(estall));
         chk("l_gnt",      32'(bus.l_gnt),      32'(who == 2));
         chk("l_rvalid",   32'(bus.l_rvalid),   32'(m_rv));
         chk("l_rdata",    bus.l_rdata,         m_rd);
         chk("p_misalign", 32'(bus.p_misalign), 32'(m_mis));
         if (who == 1 && !bus.p_we) chk("p_rdata", bus.p_rdata, shadow[ea / 4]);
      end
      if (rst) begin
         m_valid = 1'b1; m_cyc = 0; m_wait = 0; m_rv = 1'b0; m_rd = 32'd0; m_mis = 1'b0;
      end else if (m_valid) begin
         if (in_init) begin
            shadow[m_cyc] = 32'd0;
            m_cyc++;
         end
         m_rv = (who == 2) && !bus.l_we;
         if (m_rv) m_rd = shadow[ea / 4];
         if (who != 0 && ewe) shadow[ea / 4] = ewd;
         if (who == 1 && (bus.p_addr % 32'd4) != 32'd0) m_mis = 1'b1;
         if (!in_init && bus.l_req && who != 2) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
         else m_wait = 0;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin : stimulus
      int          n;
      logic [9:0]  gpat, spat;
      bus.p_req = 0; bus.p_we = 0; bus.p_addr = 0; bus.p_wdata = 0;
      bus.l_req = 0; bus.l_we = 0; bus.l_addr = 0; bus.l_wdata = 0;
      rst = 1'b1;
      repeat (2) @(posedge clock);
      #1 rst = 1'b0;
      bus.p_req = 1'b1;

      // Clear sweep: init_done first seen on cycle 257 after reset release.
      n = 0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clock);
         if (bus.init_done) begin n = i; break; end
      end
      chk("init_done_cycle", 32'(n), 32'd257);

      step(); bus.p_we = 1; bus.p_addr = 32'h40; bus.p_wdata = 32'hDEAD_BEEF;
      @(negedge clock); chk("store_stall", 32'(bus.p_stall), 32'd0);
      step(); bus.p_we = 0;
      @(negedge clock); chk("load_rdata", bus.p_rdata, 32'hDEAD_BEEF);
      chk("load_stall", 32'(bus.p_stall), 32'd0);

      step(); bus.p_req = 0; bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'h40;
      @(negedge clock); chk("lrd_gnt", 32'(bus.l_gnt), 32'd1);
      chk("lrd_addr", bus.mem_addr, 32'h40);
      step(); bus.l_req = 0;
      @(negedge clock); chk("lrd_rvalid", 32'(bus.l_rvalid), 32'd1);
      chk("lrd_rdata", bus.l_rdata, 32'hDEAD_BEEF);
      step();
      @(negedge clock); chk("lrd_rvalid_drop", 32'(bus.l_rvalid), 32'd0);

      step(); bus.p_req = 1; bus.p_addr = 32'h43;
      @(negedge clock); chk("mis_addr", bus.mem_addr, 32'h40);
      chk("mis_before", 32'(bus.p_misalign), 32'd0);
      step(); bus.p_req = 0;
      @(negedge clock); chk("mis_set", 32'(bus.p_misalign), 32'd1);
      repeat (3) step();
      @(negedge clock); chk("mis_sticky", 32'(bus.p_misalign), 32'd1);

      // Out-of-range store aliases onto word 0x40.
      step(); bus.p_req = 1; bus.p_we = 1; bus.p_addr = 32'h1040; bus.p_wdata = 32'hCAFE_0001;
      @(negedge clock); chk("wrap_addr", bus.mem_addr, 32'h40);
      step(); bus.p_we = 0; bus.p_addr = 32'h40;
      @(negedge clock); chk("wrap_rdata", bus.p_rdata, 32'hCAFE_0001);

      // Contention: L wins once every 5 cycles.
      step(); bus.p_addr = 32'h80;
      bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h100; bus.l_wdata = 32'h0000_1234;
      gpat = '0; spat = '0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) step();
         @(negedge clock);
         gpat[i] = bus.l_gnt;
         spat[i] = bus.p_stall;
      end
      chk("cont_gnt_pattern",   32'(gpat), 32'h210);
      chk("cont_stall_pattern", 32'(spat), 32'h210);

      step(); bus.p_req = 0; bus.l_we = 0;
      @(negedge clock); chk("lwr_read_gnt", 32'(bus.l_gnt), 32'd1);
      step(); bus.l_req = 0;
      @(negedge clock); chk("lwr_rdata", bus.l_rdata, 32'h0000_1234);

      // Reset right after a granted loader read.
      step(); bus.l_req = 1; bus.l_addr = 32'h40;
      @(negedge clock); chk("rst_pre_gnt", 32'(bus.l_gnt), 32'd1);
      step(); bus.l_req = 0; rst = 1'b1;
      step(); rst = 1'b0;
      @(negedge clock); chk("rst_rvalid", 32'(bus.l_rvalid), 32'd0);
      chk("rst_init_done", 32'(bus.init_done), 32'd0);
      chk("rst_addr0", bus.mem_addr, 32'h0);
      chk("rst_we", 32'(bus.mem_we), 32'd1);
      step();
      @(negedge clock); chk("rst_addr1", bus.mem_addr, 32'h4);
      repeat (5) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Owns the single data-memory port of the MEM stage.
- Shares that port between the pipeline load/store path (P) and an external loader/debug port (L).
- After reset, sequences a zero-clear sweep of the whole memory before the pipeline may access it.
- Drives the memory address, write enable and write data, and returns a stall to the pipeline hazard unit.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; BPI = DATA_W/8 bytes per word.
- MEM_WORDS, 256, memory depth in words; power of two.
- MAX_WAIT, 4, maximum cycles L may wait before forced grant; valid range 1..15.

Ports:
- clock  in  1  clock
- rst  in  1  synchronous active-high reset
- p_req  in  1  pipeline access request (load or store)
- p_we  in  1  pipeline store
- p_addr  in  ADDR_W  pipeline byte address
- p_wdata  in  DATA_W  pipeline store data
- p_stall  out  1  pipeline must hold MEM stage this cycle
- p_rdata  out  DATA_W  pipeline load data, combinational from mem_rdata
- p_misalign  out  1  sticky flag: pipeline address[1:0] was nonzero
- l_req  in  1  loader request
- l_we  in  1  loader write
- l_addr  in  ADDR_W  loader byte address
- l_wdata  in  DATA_W  loader write data
- l_gnt  out  1  loader access performed this cycle
- l_rvalid  out  1  l_rdata valid, one cycle after a read grant
- l_rdata  out  DATA_W  registered loader read data
- mem_addr  out  ADDR_W  memory byte address, word-aligned
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, combinational
- init_done  out  1  clear sweep finished

Behaviour:
- Reset: rst is synchronous and active-high; clock is clock.
  - state=INIT; sweep counter=0; wait counter=0.
  - init_done=0, l_rvalid=0, l_rdata=0, p_misalign=0.
- State INIT:
  - mem_we=1, mem_wdata=0, mem_addr=counter*BPI.
  - Counter increments each cycle.
  - p_stall=1 whenever p_req=1.
  - l_gnt=0.
  - After MEM_WORDS cycles the counter wraps and the FSM moves to RUN; init_done=1 from that cycle on.
- State RUN, arbitration per cycle:
  - If wait counter==MAX_WAIT and l_req: grant L, and p_stall=p_req.
  - Else if p_req: grant P, p_stall=0.
  - Else if l_req: grant L.
  - Else idle: mem_we=0, mem_addr=0.
- Wait counter:
  - Increments while l_req=1 and L is not granted; saturates at MAX_WAIT.
  - Clears on an L grant or when l_req=0.
- Granted port drives the memory:
  - mem_addr = addr with bits[1:0] forced 0.
  - mem_we = we.
  - mem_wdata = wdata.
- Loader read (l_gnt & !l_we): l_rdata <= mem_rdata; l_rvalid=1 for exactly the next cycle.
- p_rdata = mem_rdata at all times. Valid only when p_req & !p_we & !p_stall.
- Misalignment: p_misalign is set on a P grant with p_addr[1:0]!=0. Cleared only by rst.
- Out of range: address bits above log2(MEM_WORDS*BPI) are ignored (modulo wrap). No error is raised.
- Simultaneous P and L on the same cycle follows the priority above. Only one memory access per cycle, ever.
- rst mid-INIT or mid-RUN: the sweep restarts from 0; any pending l_rvalid is dropped.
- p_stall is combinational from p_req, state and the wait counter. There are no inputs-to-outputs loops other than rdata.

Optional Feature:
- DMEM_ARB_STATS_EN defined: adds outputs stat_stall (32) and stat_lgnt (32).
  - stat_stall counts RUN-state cycles with p_stall=1.
  - stat_lgnt counts L grants.
  - Both reset to 0 and wrap modulo 2^32.
- DMEM_ARB_STATS_EN undefined: these ports and counters do not exist.

Decomposition:
- Shared package Types holds:
  - ADDR_W/DATA_W/MEM_WORDS defaults (matching add_width, DATA, mem_depth).
  - enum ArbState_t {INIT, RUN}.
  - struct MemReq_t {we, addr, wdata}, used for both requester ports internally.
- One sub-module is natural: dmem_clear_seq, holding the INIT counter and the done flag.

Test Plan:
- Clear sweep: rst 1 cycle, MEM_WORDS=256. Expect:
  - mem_we=1 with mem_wdata=0 for 256 cycles, addresses 0x000..0x3FC.
  - init_done rises on cycle 257.
  - p_req held high gives p_stall=1 throughout the sweep.
- Pipeline store then load in RUN: store 0xDEADBEEF to 0x40, then load 0x40. Expect p_stall=0 and p_rdata=0xDEADBEEF.
- Contention with MAX_WAIT=4: p_req and l_req held constantly. Expect:
  - P granted 4 cycles, then l_gnt=1 with p_stall=1 for 1 cycle.
  - Pattern repeats every 5 cycles.
- Loader read: l_req read 0x40 while P idle. Expect l_gnt the same cycle, then l_rvalid=1 with l_rdata=0xDEADBEEF the next cycle.
- Misaligned: P load at 0x43. Expect mem_addr=0x40 and p_misalign=1 sticky until rst.
- Reset mid-RUN with a loader read granted: rst the next cycle. Expect l_rvalid=0, state INIT, sweep restarts at address 0.
